// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader for the multi-cycle CPU memory.
// Receives a 16-bit word-count header followed by big-endian 16-bit words,
// writes them to consecutive addresses from 0 while holding the CPU in
// reset, then releases the CPU and waits for its end-of-program flag.
module prog_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [7:0]        RxData,
    input  logic              RxValid,
    output logic              RxReady,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [15:0]       MemData,
    output logic              MemWE,
    output logic              CPUReset,
    input  logic              EOP,
    output logic              Done,
    output logic              Error,
    output logic [ADDR_W:0]   WordCount
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        RUN,
        HALT,
        ERR
    } state_t;

    state_t      state;
    logic [15:0] n_len;
    logic [7:0]  hi;
    logic        xfer;
    logic [15:0] len_full;

    // A byte moves only when both sides agree at the clock edge.
    assign xfer     = RxValid && RxReady;
    // Complete header as it will look once the low byte lands.
    assign len_full = {n_len[15:8], RxData};
    // The word counter doubles as the write address; the extra top bit
    // lets a full-memory load count to 2**ADDR_W without wrapping.
    assign MemAddr  = WordCount[ADDR_W-1:0];

    // Loader FSM with all outputs registered alongside the state.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= LEN_HI;
            n_len     <= 16'd0;
            hi        <= 8'd0;
            RxReady   <= 1'b0;
            MemData   <= 16'd0;
            MemWE     <= 1'b0;
            CPUReset  <= 1'b1;
            Done      <= 1'b0;
            Error     <= 1'b0;
            WordCount <= '0;
        end else begin
            MemWE <= 1'b0;
            case (state)
                LEN_HI: begin
                    RxReady <= 1'b1;
                    if (xfer) begin
                        n_len[15:8] <= RxData;
                        state       <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    RxReady <= 1'b1;
                    if (xfer) begin
                        n_len[7:0] <= RxData;
                        if (len_full == 16'd0) begin
                            state    <= RUN;
                            RxReady  <= 1'b0;
                            CPUReset <= 1'b0;
                        end else if (32'(len_full) > DEPTH) begin
                            state   <= ERR;
                            RxReady <= 1'b0;
                            Error   <= 1'b1;
                        end else begin
                            state <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    RxReady <= 1'b1;
                    if (xfer) begin
                        hi    <= RxData;
                        state <= DATA_LO;
                    end
                end
                DATA_LO: begin
                    RxReady <= 1'b1;
                    if (xfer) begin
                        // Present the word and strobe during the WRITE cycle.
                        MemData <= {hi, RxData};
                        MemWE   <= 1'b1;
                        RxReady <= 1'b0;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    WordCount <= WordCount + CNT_W'(1);
                    if (32'(WordCount) + 32'd1 == 32'(n_len)) begin
                        state    <= RUN;
                        RxReady  <= 1'b0;
                        CPUReset <= 1'b0;
                    end else begin
                        state   <= DATA_HI;
                        RxReady <= 1'b1;
                    end
                end
                RUN: begin
                    RxReady  <= 1'b0;
                    CPUReset <= 1'b0;
                    if (EOP) begin
                        state <= HALT;
                        Done  <= 1'b1;
                    end
                end
                HALT: begin
                    RxReady  <= 1'b0;
                    CPUReset <= 1'b0;
                    Done     <= 1'b1;
                end
                ERR: begin
                    RxReady  <= 1'b0;
                    CPUReset <= 1'b1;
                    Error    <= 1'b1;
                end
                default: begin
                    state   <= LEN_HI;
                    RxReady <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: drives byte streams (optionally with random
// valid gaps and EOP noise) and compares captured memory writes and status
// outputs against expectations built from the stream contents.
module tb_prog_loader;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    logic              mem_we;
    logic              cpu_reset;
    logic              eop;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    int errors = 0;
    int checks = 0;

    // Capture of what the DUT wrote, filled by the write monitor.
    logic [15:0]       obs_mem [0:DEPTH-1];
    int                we_cnt       = 0;
    int                cyc          = 0;
    int                last_we_cyc  = -1;
    int                fall_cyc     = -1;
    logic [ADDR_W-1:0] last_we_addr = '0;
    logic              prev_cr      = 1'b1;

    // Stream under test and the words it is expected to deposit.
    logic [7:0]  stream    [$];
    logic [15:0] exp_words [$];

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .CLK       (clk),
        .Reset     (rst),
        .RxData    (rx_data),
        .RxValid   (rx_valid),
        .RxReady   (rx_ready),
        .MemAddr   (mem_addr),
        .MemData   (mem_data),
        .MemWE     (mem_we),
        .CPUReset  (cpu_reset),
        .EOP       (eop),
        .Done      (done),
        .Error     (error),
        .WordCount (word_count)
    );

    always #5 clk = ~clk;

    // Passive monitor: records writes and the edge where CPUReset drops.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mem_we) begin
            obs_mem[mem_addr] = mem_data;
            we_cnt       = we_cnt + 1;
            last_we_addr = mem_addr;
            last_we_cyc  = cyc;
        end
        if (prev_cr && !cpu_reset) fall_cyc = cyc;
        prev_cr = cpu_reset;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        eop      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Build a header for n words followed by n random words.
    task automatic make_load(input int n);
        logic [15:0] w;
        stream.delete();
        exp_words.delete();
        stream.push_back(8'((n >> 8) & 255));
        stream.push_back(8'(n & 255));
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            exp_words.push_back(w);
            stream.push_back(w[15:8]);
            stream.push_back(w[7:0]);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit eop_noise);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            rx_data  = b;
            rx_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (eop_noise) eop = 1'($urandom_range(0, 1));
            if (rx_valid && rx_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_byte: byte %h not accepted, got no transfer in 64 cycles, required accept", b);
        end
    endtask

    task automatic send_stream(input bit gaps, input bit eop_noise);
        foreach (stream[i]) send_byte(stream[i], gaps, eop_noise);
        @(negedge clk);
        rx_valid = 1'b0;
        eop      = 1'b0;
    endtask

    task automatic check_words(input string name);
        foreach (exp_words[i]) begin
            checks++;
            if (obs_mem[i] !== exp_words[i]) begin
                errors++;
                $display("FAIL %s mem[%0d]: got %h required %h", name, i, obs_mem[i], exp_words[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; eop = 1'b0;
        #1;
        checks++; if (rx_ready !== 1'b0)  begin errors++; $display("FAIL rst_ready: got %b required 0", rx_ready); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpureset: got %b required 1", cpu_reset); end
        checks++; if (mem_we !== 1'b0 || mem_addr !== '0 || mem_data !== 16'd0) begin
            errors++; $display("FAIL rst_mem: got we=%b addr=%h data=%h required 0/0/0", mem_we, mem_addr, mem_data); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL rst_flags: got done=%b error=%b required 0/0", done, error); end
        checks++; if (word_count !== '0) begin errors++; $display("FAIL rst_count: got %0d required 0", word_count); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rst_len_hi_ready: got %b required 1", rx_ready); end
    endtask

    task automatic test_basic();
        int base;
        do_reset();
        stream    = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        exp_words = '{16'h1234, 16'hABCD};
        base = we_cnt;
        send_stream(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_words("basic");
        checks++; if (we_cnt - base !== 2) begin errors++; $display("FAIL basic_we_count: got %0d required 2", we_cnt - base); end
        checks++; if (word_count !== 11'd2) begin errors++; $display("FAIL basic_wordcount: got %0d required 2", word_count); end
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL basic_release: got %b required 0", cpu_reset); end
        checks++; if (fall_cyc !== last_we_cyc + 1) begin
            errors++; $display("FAIL basic_release_timing: got cycle %0d required %0d", fall_cyc, last_we_cyc + 1); end
        checks++; if (done !== 1'b0 || rx_ready !== 1'b0) begin
            errors++; $display("FAIL basic_run_state: got done=%b ready=%b required 0/0", done, rx_ready); end
    endtask

    task automatic test_empty();
        int base;
        do_reset();
        make_load(0);
        base = we_cnt;
        send_stream(1'b0, 1'b0);
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL empty_release: got %b required 0", cpu_reset); end
        repeat (4) @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL empty_done_early: got %b required 0", done); end
        eop = 1'b1;
        @(posedge clk); #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL empty_done: got %b required 1", done); end
        @(negedge clk);
        eop = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin
            errors++; $display("FAIL empty_halt: got done=%b cpureset=%b required 1/0", done, cpu_reset); end
        checks++; if (we_cnt - base !== 0) begin errors++; $display("FAIL empty_no_write: got %0d writes required 0", we_cnt - base); end
    endtask

    task automatic test_len_err();
        int base;
        do_reset();
        stream = '{8'h04, 8'h01};
        base = we_cnt;
        send_stream(1'b0, 1'b0);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_flag: got %b required 1", error); end
        checks++; if (rx_ready !== 1'b0 || cpu_reset !== 1'b1) begin
            errors++; $display("FAIL err_state: got ready=%b cpureset=%b required 0/1", rx_ready, cpu_reset); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            eop      = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        eop      = 1'b0;
        checks++; if (we_cnt - base !== 0) begin errors++; $display("FAIL err_no_write: got %0d writes required 0", we_cnt - base); end
        checks++; if (error !== 1'b1 || rx_ready !== 1'b0 || cpu_reset !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL err_sticky: got err=%b ready=%b cpureset=%b done=%b required 1/0/1/0", error, rx_ready, cpu_reset, done); end
        checks++; if (word_count !== '0) begin errors++; $display("FAIL err_count: got %0d required 0", word_count); end
    endtask

    task automatic test_full();
        int base;
        do_reset();
        make_load(DEPTH);
        base = we_cnt;
        send_stream(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_words("full");
        checks++; if (we_cnt - base !== DEPTH) begin errors++; $display("FAIL full_we_count: got %0d required %0d", we_cnt - base, DEPTH); end
        checks++; if (word_count !== 11'(DEPTH)) begin errors++; $display("FAIL full_wordcount: got %0d required %0d", word_count, DEPTH); end
        checks++; if (last_we_addr !== 10'h3FF) begin errors++; $display("FAIL full_last_addr: got %h required 3ff", last_we_addr); end
        checks++; if (cpu_reset !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL full_run: got cpureset=%b error=%b required 0/0", cpu_reset, error); end
    endtask

    task automatic test_gaps();
        int base;
        do_reset();
        make_load(3);
        base = we_cnt;
        send_stream(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check_words("gaps");
        checks++; if (we_cnt - base !== 3) begin errors++; $display("FAIL gaps_we_count: got %0d required 3", we_cnt - base); end
        checks++; if (word_count !== 11'd3) begin errors++; $display("FAIL gaps_wordcount: got %0d required 3", word_count); end
        checks++; if (done !== 1'b0 || cpu_reset !== 1'b0) begin
            errors++; $display("FAIL gaps_eop_ignored: got done=%b cpureset=%b required 0/0", done, cpu_reset); end
    endtask

    task automatic test_mid_reset();
        int base;
        do_reset();
        stream = '{8'h00, 8'h02, 8'h11, 8'h11, 8'h22};
        base = we_cnt;
        send_stream(1'b0, 1'b0);
        checks++; if (we_cnt - base !== 1) begin errors++; $display("FAIL mid_partial_writes: got %0d required 1", we_cnt - base); end
        rst = 1'b1;
        #1;
        checks++; if (rx_ready !== 1'b0 || cpu_reset !== 1'b1 || word_count !== '0) begin
            errors++; $display("FAIL mid_reset_state: got ready=%b cpureset=%b count=%0d required 0/1/0", rx_ready, cpu_reset, word_count); end
        @(negedge clk);
        rst = 1'b0;
        stream    = '{8'h00, 8'h01, 8'h55, 8'hAA};
        exp_words = '{16'h55AA};
        base = we_cnt;
        send_stream(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_words("mid_reload");
        checks++; if (we_cnt - base !== 1) begin errors++; $display("FAIL mid_reload_writes: got %0d required 1", we_cnt - base); end
        checks++; if (cpu_reset !== 1'b0 || word_count !== 11'd1) begin
            errors++; $display("FAIL mid_reload_run: got cpureset=%b count=%0d required 0/1", cpu_reset, word_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_len_err();
        test_full();
        test_gaps();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader sitting in front of the instruction/data memory of the multi-cycle CPU.
- While loading, it holds the CPU in reset, assembles incoming bytes into 16-bit words and writes them to consecutive memory addresses starting at 0.
- After the last word is written it releases the CPU.
- It then watches the control unit's EOP flag to report program completion, so it is the producer-side counterpart to the instruction-consuming control unit.

Parameters:
- ADDR_W, 10, memory word-address width; capacity is 2**ADDR_W words.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- RxData  input  8  incoming byte.
- RxValid  input  1  RxData valid this cycle.
- RxReady  output  1  loader can accept a byte; a byte transfers when RxValid && RxReady at a rising edge.
- MemAddr  output  ADDR_W  memory write address.
- MemData  output  16  memory write data.
- MemWE  output  1  one-cycle memory write strobe.
- CPUReset  output  1  held high to keep the CPU (control unit Reset) in reset.
- EOP  input  1  end-of-program flag from the control unit.
- Done  output  1  program completed (sticky).
- Error  output  1  illegal length header (sticky).
- WordCount  output  ADDR_W+1  number of words written so far.

Behaviour:
- Clock and reset:
  - Reset is asynchronous, active-high.
  - CLK is the single clock; the block uses its rising edge only.
- Reset values:
  - State = LEN_HI.
  - RxReady = 0 during reset, then 1 in LEN_HI.
  - MemAddr = 0, MemData = 0, MemWE = 0.
  - CPUReset = 1, Done = 0, Error = 0, WordCount = 0.
  - Internal length register N = 0.
- Stream format:
  - Header: 16-bit word count N, high byte first.
  - Payload: N words, each high byte then low byte.
- States:
  - LEN_HI: RxReady = 1. On transfer, N[15:8] <= RxData; go to LEN_LO.
  - LEN_LO: RxReady = 1. On transfer, N[7:0] <= RxData, then:
    - full N == 0 -> RUN.
    - N > 2**ADDR_W -> ERR.
    - otherwise -> DATA_HI.
  - DATA_HI: RxReady = 1. On transfer, hi <= RxData; go to DATA_LO.
  - DATA_LO: RxReady = 1. On transfer, lo <= RxData; go to WRITE.
  - WRITE: RxReady = 0.
    - MemWE = 1 for exactly this cycle, with MemAddr = current address and MemData = {hi, lo} stable for the same cycle.
    - At the end of the cycle, address and WordCount increment.
    - If WordCount+1 == N -> RUN, else -> DATA_HI.
  - RUN: RxReady = 0, CPUReset = 0. When EOP is sampled high -> HALT.
  - HALT: CPUReset = 0, Done = 1, RxReady = 0. Stays in HALT until Reset.
  - ERR: Error = 1, CPUReset = 1, RxReady = 0. Stays in ERR until Reset.
- Latency:
  - Minimum 3 cycles per word: hi, lo, write.
  - RxValid gaps simply stall in DATA_HI/DATA_LO with no timeout.
- CPUReset timing: falls on the first cycle of RUN, i.e. the cycle after the final MemWE.
- Address counter:
  - ADDR_W+1 bits internally; MemAddr is its low ADDR_W bits.
  - N == 2**ADDR_W fills memory exactly with no wrap.
- Ignored inputs:
  - Bytes offered outside the receive states are not accepted (RxReady = 0).
  - EOP is ignored in every state other than RUN, including while loading.
- Reset mid-load:
  - Returns to LEN_HI immediately, CPUReset = 1.
  - Partially written memory is not cleared.
  - WordCount = 0.
- MemWE is never asserted outside WRITE.

Test Plan:
1. Reset, then stream 00 02 12 34 AB CD with RxValid always high:
   - MemWE pulses twice: addr 0 = 0x1234, addr 1 = 0xABCD.
   - WordCount = 2.
   - CPUReset falls the cycle after the second MemWE.
2. Header 00 00:
   - No MemWE.
   - CPUReset falls immediately after LEN_LO accept.
   - Assert EOP 5 cycles later -> Done = 1 the next cycle; CPUReset stays 0.
3. ADDR_W = 10, header 04 01 (N = 1025):
   - ERR state: Error = 1, RxReady = 0, CPUReset stays 1.
   - Further bytes are not accepted; no MemWE.
4. Header 04 00 (N = 1024) with 1024 words:
   - Last write at MemAddr 0x3FF, WordCount = 1024, no wrap write to 0.
   - Then RUN.
5. N = 3 with RxValid toggled randomly:
   - Identical memory contents to the gap-free case; MemWE count = 3.
   - EOP pulses during loading are ignored: Done stays 0.
6. Assert Reset after 3 payload bytes of an N = 2 load:
   - Immediately: RxReady low, CPUReset = 1, WordCount = 0.
   - A fresh stream 00 01 55 AA then writes addr 0 = 0x55AA and releases the CPU.
